systolic_job_driver: RTL

- Host-side sequencer for the 4x4 systolic multiplier. Accepts one job per handshake (16 weights plus 4 inputs, packed) and serializes it into the array's nibble-wide load protocol.
- Waits for the array's result strobe, captures the four 8-bit results, and presents them downstream under valid/ready.
- Owns the array's active-high reset and uses it for timeout recovery.

---
 rtl/systolic_job_driver.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/systolic_job_driver.sv
// Host-side sequencer for the 4x4 systolic multiplier: takes one packed job per handshake and
// serializes it as nibbles. It then waits for the result strobe and recovers the array on a timeout.
module systolic_job_driver #(
  parameter int unsigned TIMEOUT        = 16,
  parameter int unsigned RECOVER_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [63:0] job_weights,
  input  logic [15:0] job_inputs,
  input  logic        job_reuse_weights,
  output logic        arr_reset,
  output logic [3:0]  arr_data_in,
  output logic        arr_load_weights,
  output logic        arr_load_inputs,
  input  logic [31:0] arr_results,
  input  logic        arr_valid_out,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_err,
  output logic        spurious_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_LOAD_I,
    S_WAIT,
    S_RECOVER,
    S_HOLD
  } state_e;

  localparam logic [7:0]  TO_LAST = 8'(TIMEOUT - 1);
  localparam logic [15:0] RC_LAST = 16'(RECOVER_CYCLES - 1);

  state_e      state_q;
  logic [63:0] weights_q;
  logic [15:0] inputs_q;
  logic        wloaded_q;
  logic [4:0]  idx_q;
  logic [7:0]  wcnt_q;
  logic [15:0] rcnt_q;

  logic        job_ready_q;
  logic        arr_reset_q;
  logic [3:0]  data_q;
  logic        load_w_q;
  logic        load_i_q;
  logic        res_valid_q;
  logic [31:0] res_data_q;
  logic        res_err_q;
  logic        spurious_q;

  assign job_ready        = job_ready_q;
  assign arr_reset        = arr_reset_q;
  assign arr_data_in      = data_q;
  assign arr_load_weights = load_w_q;
  assign arr_load_inputs  = load_i_q;
  assign res_valid        = res_valid_q;
  assign res_data         = res_data_q;
  assign res_err          = res_err_q;
  assign spurious_valid   = spurious_q;

  // Strobe outputs are set one edge ahead: idx_q is the next element to present.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      weights_q   <= '0;
      inputs_q    <= '0;
      wloaded_q   <= 1'b0;
      idx_q       <= '0;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      job_ready_q <= 1'b0;
      arr_reset_q <= 1'b1;
      data_q      <= '0;
      load_w_q    <= 1'b0;
      load_i_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      spurious_q  <= 1'b0;
    end else begin
      if (arr_valid_out && (state_q != S_WAIT)) spurious_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (arr_reset_q) begin
            arr_reset_q <= 1'b0;
          end else if (job_ready_q && job_valid) begin
            weights_q   <= job_weights;
            inputs_q    <= job_inputs;
            job_ready_q <= 1'b0;
            idx_q       <= 5'd1;
            if (job_reuse_weights && wloaded_q) begin
              state_q  <= S_LOAD_I;
              load_i_q <= 1'b1;
              data_q   <= job_inputs[3:0];
            end else begin
              state_q  <= S_LOAD_W;
              load_w_q <= 1'b1;
              data_q   <= job_weights[3:0];
            end
          end else begin
            job_ready_q <= 1'b1;
          end
        end

        S_LOAD_W: begin
          if (idx_q == 5'd16) begin
            wloaded_q <= 1'b1;
            state_q   <= S_LOAD_I;
            load_w_q  <= 1'b0;
            load_i_q  <= 1'b1;
            data_q    <= inputs_q[3:0];
            idx_q     <= 5'd1;
          end else begin
            data_q <= weights_q[{idx_q[3:0], 2'b00} +: 4];
            idx_q  <= idx_q + 5'd1;
          end
        end

        S_LOAD_I: begin
          if (idx_q == 5'd4) begin
            load_i_q <= 1'b0;
            data_q   <= '0;
            wcnt_q   <= '0;
            state_q  <= S_WAIT;
          end else begin
            data_q <= inputs_q[{idx_q[1:0], 2'b00} +: 4];
            idx_q  <= idx_q + 5'd1;
          end
        end

        S_WAIT: begin
          if (arr_valid_out) begin
            res_data_q  <= arr_results;
            res_err_q   <= 1'b0;
            res_valid_q <= 1'b1;
            state_q     <= S_HOLD;
          end else if (wcnt_q == TO_LAST) begin
            arr_reset_q <= 1'b1;
            wloaded_q   <= 1'b0;
            rcnt_q      <= '0;
            state_q     <= S_RECOVER;
          end else begin
            wcnt_q <= wcnt_q + 8'd1;
          end
        end

        S_RECOVER: begin
          if (rcnt_q == RC_LAST) begin
            arr_reset_q <= 1'b0;
            res_data_q  <= '0;
            res_err_q   <= 1'b1;
            res_valid_q <= 1'b1;
            state_q     <= S_HOLD;
          end else begin
            rcnt_q <= rcnt_q + 16'd1;
          end
        end

        S_HOLD: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
